fphub_adder_pipe: RTL and testbench

- Pipelined, parametrised HUB floating-point adder/subtractor. Successor to the combinational FPHUB adder core.
- Accepts one operation per cycle under a valid/ready handshake and produces a result after three register stages.
- Adds an add/sub mode, saturation and flush-to-zero flags, and an optional debug tap.
- Sits between the operand-fetch stage and the result writeback of the HUB arithmetic datapath.

---
 rtl/fphub_adder_pipe.sv | 175 +++++++++++++++++
 tb/tb_fphub_adder_pipe.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/fphub_adder_pipe.sv
// Three-stage pipelined HUB floating-point adder/subtractor with valid/ready handshake.
// Define FPHUB_DEBUG_EN to expose registered internal datapath taps (dbg_* outputs).
module fphub_adder_pipe #(
  parameter int unsigned M = 4,
  parameter int unsigned E = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_sub,
  input  logic [E+M:0]     X,
  input  logic [E+M:0]     Y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [E+M:0]     Z,
  output logic             ovf,
  output logic             unf
`ifdef FPHUB_DEBUG_EN
  ,
  output logic [E:0]             dbg_ez,
  output logic [$clog2(M+3)-1:0] dbg_lz,
  output logic                   dbg_sub,
  output logic [M+2:0]           dbg_major,
  output logic [M+2:0]           dbg_minor
`endif
);

  localparam int unsigned W  = E + M + 1;
  localparam int unsigned XW = M + 3;
  localparam int unsigned DW = $clog2(M + 4);
  localparam int unsigned LW = $clog2(M + 3);

  logic advance;
  assign advance  = out_ready | ~out_valid;
  assign in_ready = advance;

  // Stage 1: unpack and compare
  logic          sy_eff, x_zero, y_zero, y_maj;
  logic [E+M-1:0] kx, ky;
  logic [E-1:0]  emaj_c, emin_c, ediff;
  logic [M-1:0]  mmaj_c, mmin_c;
  logic [DW-1:0] d_c;

  always_comb begin
    sy_eff = Y[W-1] ^ op_sub;
    x_zero = (X[W-2:M] == '0);
    y_zero = (Y[W-2:M] == '0);
    // Zero operands compare as the smallest key regardless of their mantissa field
    kx     = x_zero ? '0 : X[W-2:0];
    ky     = y_zero ? '0 : Y[W-2:0];
    y_maj  = (ky > kx);
    emaj_c = y_maj ? Y[W-2:M] : X[W-2:M];
    emin_c = y_maj ? X[W-2:M] : Y[W-2:M];
    mmaj_c = y_maj ? Y[M-1:0] : X[M-1:0];
    mmin_c = y_maj ? X[M-1:0] : Y[M-1:0];
    ediff  = emaj_c - emin_c;
    if (int'(ediff) > int'(M) + 3) d_c = DW'(M + 3);
    else                           d_c = DW'(ediff);
  end

  logic          v1, s1, sub1, majz1, minz1;
  logic [E-1:0]  e1;
  logic [M-1:0]  mmaj1, mmin1;
  logic [DW-1:0] d1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0; s1 <= 1'b0; sub1 <= 1'b0; majz1 <= 1'b0; minz1 <= 1'b0;
      e1 <= '0; mmaj1 <= '0; mmin1 <= '0; d1 <= '0;
    end else if (advance) begin
      v1    <= in_valid;
      s1    <= y_maj ? sy_eff : X[W-1];
      sub1  <= X[W-1] ^ sy_eff;
      majz1 <= y_maj ? y_zero : x_zero;
      minz1 <= y_maj ? x_zero : y_zero;
      e1    <= emaj_c;
      mmaj1 <= mmaj_c;
      mmin1 <= mmin_c;
      d1    <= d_c;
    end
  end

  // Stage 2: align and add
  logic [XW-1:0] maj_a, min_a, sum_c;

  always_comb begin
    maj_a = {2'b01, mmaj1, 1'b1};
    min_a = minz1 ? '0 : ({2'b01, mmin1, 1'b1} >> d1);
    if (majz1)     sum_c = '0;
    else if (sub1) sum_c = maj_a - min_a;
    else           sum_c = maj_a + min_a;
  end

  logic          v2, s2;
  logic [E-1:0]  e2;
  logic [XW-1:0] sum2;
`ifdef FPHUB_DEBUG_EN
  logic          sub2;
  logic [XW-1:0] maj2, min2;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2 <= 1'b0; s2 <= 1'b0; e2 <= '0; sum2 <= '0;
`ifdef FPHUB_DEBUG_EN
      sub2 <= 1'b0; maj2 <= '0; min2 <= '0;
`endif
    end else if (advance) begin
      v2   <= v1;
      s2   <= s1;
      e2   <= e1;
      sum2 <= sum_c;
`ifdef FPHUB_DEBUG_EN
      sub2 <= sub1;
      maj2 <= maj_a;
      min2 <= min_a;
`endif
    end
  end

  // Stage 3: normalise and pack
  logic          carry, ovf_c, unf_c;
  logic [LW-1:0] lz;
  logic [E+1:0]  ez;
  logic [M-1:0]  mant_c;
  logic [W-1:0]  z_c;

  always_comb begin
    carry = sum2[XW-1];
    lz    = '0;
    for (int i = 0; i <= int'(M) + 1; i++) begin
      if (sum2[i]) lz = LW'(int'(M) + 1 - i);
    end
    // ez is two's complement, wide enough for both Emax+1 and the most negative Emaj-lz
    if (carry) ez = {2'b00, e2} + (E+2)'(1);
    else       ez = {2'b00, e2} - (E+2)'(lz);
    mant_c = carry ? sum2[M+1:2] : M'((sum2 << lz) >> 1);
    ovf_c  = 1'b0;
    unf_c  = 1'b0;
    if (sum2 == '0) begin
      z_c = '0;
    end else if (!ez[E+1] && ez[E]) begin
      z_c   = {s2, {(E+M){1'b1}}};
      ovf_c = 1'b1;
    end else if (ez[E+1] || ez == '0) begin
      z_c   = '0;
      unf_c = 1'b1;
    end else begin
      z_c = {s2, ez[E-1:0], mant_c};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0; Z <= '0; ovf <= 1'b0; unf <= 1'b0;
`ifdef FPHUB_DEBUG_EN
      dbg_ez <= '0; dbg_lz <= '0; dbg_sub <= 1'b0; dbg_major <= '0; dbg_minor <= '0;
`endif
    end else if (advance) begin
      out_valid <= v2;
      Z         <= v2 ? z_c : '0;
      ovf       <= v2 & ovf_c;
      unf       <= v2 & unf_c;
`ifdef FPHUB_DEBUG_EN
      dbg_ez    <= ez[E:0];
      dbg_lz    <= carry ? '0 : lz;
      dbg_sub   <= sub2;
      dbg_major <= maj2;
      dbg_minor <= min2;
`endif
    end
  end

endmodule

// File: tb/tb_fphub_adder_pipe.sv
// Directed self-checking bench for fphub_adder_pipe (M=E=4, default build).
module tb_fphub_adder_pipe;

  logic       clk, rst, in_valid, in_ready, op_sub, out_valid, out_ready, ovf, unf;
  logic [8:0] X, Y, Z;

  int n_cmp = 0;
  int n_err = 0;

  fphub_adder_pipe #(.M(4), .E(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op_sub   (op_sub),
    .X        (X),
    .Y        (Y),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Z        (Z),
    .ovf      (ovf),
    .unf      (unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Single operation on an idle pipe; measures latency from the accepting edge.
  task automatic run_op(input string tag, input logic [8:0] x, input logic [8:0] y,
                        input logic sub, input logic [8:0] ez, input logic eo, input logic eu);
    int cnt;
    X = x; Y = y; op_sub = sub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cnt = 1;
    while (!out_valid && cnt < 10) begin
      @(posedge clk); #1;
      cnt++;
    end
    check({tag, "_lat"}, cnt, 3);
    check({tag, "_z"}, {23'd0, Z}, {23'd0, ez});
    check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
    check({tag, "_unf"}, {31'd0, unf}, {31'd0, eu});
    @(posedge clk); #1;
  endtask

  logic [8:0] xs [4];
  logic [8:0] ys [4];
  logic       subs [4];
  logic [8:0] exps [4];

  initial begin
    rst = 1'b1; in_valid = 1'b0; op_sub = 1'b0; X = '0; Y = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, out_valid}, 0);
    check("rst_z", {23'd0, Z}, 0);
    check("rst_ovf", {31'd0, ovf}, 0);
    check("rst_unf", {31'd0, unf}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("add_eq",   9'h070, 9'h070, 1'b0, 9'h080, 1'b0, 1'b0);
    run_op("sub_eq",   9'h070, 9'h070, 1'b1, 9'h000, 1'b0, 1'b0);
    run_op("zero_x",   9'h000, 9'h135, 1'b0, 9'h135, 1'b0, 1'b0);
    run_op("sat",      9'h0FF, 9'h0FF, 1'b0, 9'h0FF, 1'b1, 1'b0);
    run_op("flush",    9'h010, 9'h118, 1'b0, 9'h000, 1'b0, 1'b1);
    run_op("align",    9'h070, 9'h060, 1'b0, 9'h078, 1'b0, 1'b0);
    run_op("sub_neg",  9'h070, 9'h170, 1'b1, 9'h080, 1'b0, 1'b0);
    run_op("ymaj_sub", 9'h060, 9'h070, 1'b1, 9'h161, 1'b0, 1'b0);
    run_op("negzero",  9'h100, 9'h100, 1'b0, 9'h000, 1'b0, 1'b0);
    run_op("zero_man", 9'h105, 9'h135, 1'b0, 9'h135, 1'b0, 1'b0);

    xs[0] = 9'h070; ys[0] = 9'h070; subs[0] = 1'b0; exps[0] = 9'h080;
    xs[1] = 9'h070; ys[1] = 9'h060; subs[1] = 1'b0; exps[1] = 9'h078;
    xs[2] = 9'h000; ys[2] = 9'h135; subs[2] = 1'b0; exps[2] = 9'h135;
    xs[3] = 9'h060; ys[3] = 9'h070; subs[3] = 1'b1; exps[3] = 9'h161;

    // Back-to-back, no stall
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        X = xs[i]; Y = ys[i]; op_sub = subs[i]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      if (i >= 2) begin
        check("b2b_valid", {31'd0, out_valid}, 1);
        check("b2b_z", {23'd0, Z}, {23'd0, exps[i-2]});
      end
    end
    @(posedge clk); #1;
    check("b2b_drain", {31'd0, out_valid}, 0);

    // Backpressure: three ops fill the pipe, then the output stalls
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      X = xs[i]; Y = ys[i]; op_sub = subs[i]; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("bp_ready", {31'd0, in_ready}, 0);
      check("bp_z", {23'd0, Z}, {23'd0, exps[0]});
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("bp_rel_valid", {31'd0, out_valid}, 1);
      check("bp_rel_z", {23'd0, Z}, {23'd0, exps[i]});
      @(posedge clk); #1;
    end
    check("bp_empty", {31'd0, out_valid}, 0);

    // Asynchronous reset with ops in flight
    for (int i = 0; i < 3; i++) begin
      X = xs[i]; Y = ys[i]; op_sub = subs[i]; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("pre_rst_valid", {31'd0, out_valid}, 1);
    rst = 1'b1;
    #1;
    check("rst_async_valid", {31'd0, out_valid}, 0);
    check("rst_async_z", {23'd0, Z}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("post_rst_stale", {31'd0, out_valid}, 0);
    end
    run_op("post_rst", 9'h070, 9'h070, 1'b0, 9'h080, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
